lemmings_walker: RTL

- Parametrised multi-channel Lemmings controller. Each channel is an independent Moore FSM.
- Behaviours: walk left/right, bounce off obstacles, fall when the ground disappears, dig on command, and splat after an over-long fall.
- Sits in the game-logic cluster; supersedes the two-state walk-only controller.
- Adds falling, digging, fall-duration counting and a terminal splat state, replicated across NUM_CH channels.

---
 rtl/lemmings_pkg.sv | 24 ++
 rtl/lemming_ch.sv | 75 +++++++
 rtl/lemmings_walker.sv | 48 ++++
 3 files changed

// File: rtl/lemmings_pkg.sv
// Shared types and helpers for the multi-channel Lemmings controller.
// The state encoding keeps WALK_L at zero so a cleared register means "walking left".
package lemmings_pkg;

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } lem_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lemming_ch.sv
// One Lemmings channel: Moore FSM with a saturating fall-length counter.
// Outputs are registered copies of the next-state decode, so they never depend on inputs combinationally.
module lemming_ch
  import lemmings_pkg::*;
#(
  parameter int SPLAT_CYCLES = 20,
  parameter int CNT_W        = clog2(SPLAT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic splat
);

  lem_state_t       state;
  lem_state_t       nxt;
  logic [CNT_W-1:0] fall_cnt;
  logic             too_long;

  function automatic lem_state_t next_state(input lem_state_t s,
                                            input logic bl, input logic br,
                                            input logic gr, input logic dg,
                                            input logic fatal);
    lem_state_t n;
    n = s;
    unique case (s)
      WALK_L: if (!gr) n = FALL_L; else if (dg) n = DIG_L; else if (bl) n = WALK_R;
      WALK_R: if (!gr) n = FALL_R; else if (dg) n = DIG_R; else if (br) n = WALK_L;
      DIG_L:  if (!gr) n = FALL_L;
      DIG_R:  if (!gr) n = FALL_R;
      FALL_L: if (gr) n = fatal ? SPLAT : WALK_L;
      FALL_R: if (gr) n = fatal ? SPLAT : WALK_R;
      SPLAT:  n = SPLAT;
      default: n = WALK_L;
    endcase
    return n;
  endfunction

  // fall_cnt holds the 0-based index of the current fall cycle, so reaching
  // SPLAT_CYCLES means this is already fall cycle SPLAT_CYCLES+1.
  assign too_long = (fall_cnt >= CNT_W'(SPLAT_CYCLES));
  assign nxt      = next_state(state, bump_left, bump_right, ground, dig, too_long);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WALK_L;
      fall_cnt   <= '0;
      walk_left  <= 1'b1;
      walk_right <= 1'b0;
      aaah       <= 1'b0;
      digging    <= 1'b0;
      splat      <= 1'b0;
    end else begin
      state <= nxt;
      if (state == FALL_L || state == FALL_R) begin
        if (!too_long) fall_cnt <= fall_cnt + CNT_W'(1);
      end else begin
        fall_cnt <= '0;
      end
      walk_left  <= (nxt == WALK_L);
      walk_right <= (nxt == WALK_R);
      aaah       <= (nxt == FALL_L) || (nxt == FALL_R);
      digging    <= (nxt == DIG_L) || (nxt == DIG_R);
      splat      <= (nxt == SPLAT);
    end
  end

endmodule

// File: rtl/lemmings_walker.sv
// NUM_CH independent Lemmings channels sharing only clock and reset.
module lemmings_walker
  import lemmings_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SPLAT_CYCLES = 20,
  parameter int CNT_W        = clog2(SPLAT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] bump_left,
  input  logic [NUM_CH-1:0] bump_right,
  input  logic [NUM_CH-1:0] ground,
  input  logic [NUM_CH-1:0] dig,
  output logic [NUM_CH-1:0] walk_left,
  output logic [NUM_CH-1:0] walk_right,
  output logic [NUM_CH-1:0] aaah,
  output logic [NUM_CH-1:0] digging,
  output logic [NUM_CH-1:0] splat
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("lemmings_walker: NUM_CH must be >= 1");
  end
  if (SPLAT_CYCLES < 1) begin : g_bad_splat
    $error("lemmings_walker: SPLAT_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lemming_ch #(
      .SPLAT_CYCLES (SPLAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .bump_left  (bump_left[i]),
      .bump_right (bump_right[i]),
      .ground     (ground[i]),
      .dig        (dig[i]),
      .walk_left  (walk_left[i]),
      .walk_right (walk_right[i]),
      .aaah       (aaah[i]),
      .digging    (digging[i]),
      .splat      (splat[i])
    );
  end

endmodule
